// File: rtl/fixed_point_add_pkg.sv
// Shared types and helpers for the sequenced multi-word adder.
// The sequencer imports this package for its state encoding and index width.
package fixed_point_add_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add_seq_state_t;

    // Word index width; a single-word operation still carries a 1-bit index.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/ripple_add_slice.sv
// Combinational N-bit adder slice with carry in and carry out.
// The sequencer reuses one instance of it for every word of an operation.
module ripple_add_slice #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two N*WORDS-bit operands with a single N-bit slice, one word per clock,
// least-significant word first, with the carry held in a register between words.
module multiword_add_sequencer
    import fixed_point_add_pkg::*;
#(
    parameter int N     = 32,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               carry_out,
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int IW = idx_width(WORDS);

    add_seq_state_t state_reg;
    add_seq_state_t state_next;

    logic [IW-1:0] idx_reg;
    logic          carry_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic          carry_out_reg;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic [N-1:0]  slice_sum;
    logic          slice_carry;
    logic          last_word;
    logic          accept;

    // Handshake outputs depend on state only; in_ready is additionally held low during reset.
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

    assign accept    = in_valid && in_ready;
    assign last_word = (idx_reg == IW'(WORDS - 1));
    assign slice_a   = a_reg[int'(idx_reg) * N +: N];
    assign slice_b   = b_reg[int'(idx_reg) * N +: N];

    ripple_add_slice #(
        .N(N)
    ) u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .carry_in (carry_reg),
        .sum      (slice_sum),
        .carry_out(slice_carry)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_word) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[int'(idx_reg) * N +: N] <= slice_sum;
                    carry_reg                       <= slice_carry;
                    // Index parks on the last word rather than wrapping.
                    if (last_word) begin
                        carry_out_reg <= slice_carry;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
